cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Control sequencer for the single-cycle 8-bit CPU datapath.
- Decodes the 5-bit opcodeFunc together with the C/Z flags into every datapath control line (aluOp, write enables, mux selects, push/pop).
- Wraps decoding in a run-control FSM (idle/run/halt/fault) with single-step support, a PC write enable, a shadow stack-depth counter for overflow/underflow trapping, and a retired-instruction counter.
- Sits beside the datapath; the datapath PC register is gated by pcEn.

Parameters:
- STACK_DEPTH, 8: entries in the datapath return stack. Legal range 2..15.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  leave IDLE and begin execution
- stepMode  in  1  level; when 1, execute only in cycles where step=1
- step  in  1  single-cycle pulse; permits one instruction in step mode
- opcodeFunc  in  5  decoded opcode field from instruction memory
- halt  in  1  current instruction is HALT
- Cout  in  1  carry flag from datapath
- Zout  in  1  zero flag from datapath
- aluOp  out  4  ALU operation select
- regWriteEn, memWriteEn, cWriteEn, zWriteEn  out  1 each  write enables
- immAndmem, stm, ldm, branch, jmp, ret, push, pop  out  1 each  mux selects and stack controls
- pcEn  out  1  PC register write enable
- running, halted, faulted  out  1 each  FSM status
- faultCode  out  2  00 none, 01 illegal opcode, 10 stack overflow, 11 stack underflow
- stackDepth  out  4  shadow stack occupancy
- retireCount  out  CNT_W  instructions executed

Behaviour:
- FSM states: IDLE, RUN, HALTED, FAULT.
  - IDLE: start → RUN.
  - RUN: halt → HALTED, fault condition → FAULT.
  - HALTED and FAULT are left only by rst.
  - start is ignored outside IDLE.
- exec = (state==RUN) & (~stepMode | step).
- Decode is combinational (Mealy) from opcodeFunc/Cout/Zout, so the controls are valid in the same cycle as the instruction.
- When exec=0, or for any halting or faulting instruction, all enables, push, pop, branch, jmp, ret and pcEn are 0 and aluOp=0000.
- Opcode map:
  - 00fff: R-type ALU. aluOp={0,fff} (ADD, ADC, SUB, SBC, AND, OR, XOR, MASK). regWriteEn, cWriteEn, zWriteEn=1.
  - 01fff: immediate ALU. Same as R-type plus immAndmem=1.
  - 10000 LDM: aluOp=0000, immAndmem=1, ldm=1, regWriteEn=1.
  - 10001 STM: aluOp=0000, immAndmem=1, stm=1, memWriteEn=1.
  - 10010–10101 shift/rotate: aluOp=1000–1011, regWriteEn, cWriteEn, zWriteEn=1.
  - 11000 JMP: jmp=1.
  - 11001 JSB: jmp=1, push=1.
  - 11010 RET: ret=1, pop=1.
  - 11100 BZ: branch=Zout. 11101 BNZ: branch=~Zout. 11110 BC: branch=Cout. 11111 BNC: branch=~Cout.
  - 10110, 10111, 11011, 11x?? not listed: illegal.
- pcEn=1 on every executed instruction.
- Evaluation priority within one exec cycle:
  1. halt=1 → HALTED, nothing executed, retireCount unchanged.
  2. Illegal opcode → FAULT, faultCode=01.
  3. JSB with stackDepth==STACK_DEPTH → FAULT, code 10.
  4. RET with stackDepth==0 → FAULT, code 11.
  5. Otherwise execute.
- stackDepth: +1 on executed JSB, −1 on executed RET; otherwise held.
- retireCount: +1 per executed instruction, including not-taken branches; wraps modulo 2^CNT_W.
- Status outputs are registered and reflect the current state:
  - running=(RUN).
  - halted=(HALTED).
  - faulted=(FAULT); faultCode is held until rst.
- rst (any state, any cycle) → IDLE, stackDepth=0, retireCount=0, faultCode=00. All outputs are 0 during and after reset until execution.
- A step pulse while stepMode=0 has no extra effect. step in IDLE is ignored.

Test Plan:
- rst, start, then opcodeFunc=00010 for 3 cycles → aluOp=0010; regWriteEn=cWriteEn=zWriteEn=pcEn=1 each cycle; retireCount=3.
- RUN, Zout=1, opcodeFunc=11100 → branch=1. Zout=0 with 11100 → branch=0, pcEn=1, retireCount still +1.
- stepMode=1, opcodeFunc=10000 held 5 cycles, step pulsed twice → ldm/regWriteEn high only in those 2 cycles; retireCount=2.
- 8 consecutive JSB (11001) → stackDepth=8. 9th JSB → push=0, pcEn=0, faulted=1, faultCode=10. Rst → all cleared.
- RET in RUN with stackDepth=0 → pop=0, FAULT, faultCode=11. Separately, opcodeFunc=10110 → FAULT, code 01.
- halt=1 together with opcodeFunc=00000 → no enables, halted=1 next cycle, retireCount unchanged. start then ignored. rst mid-RUN → IDLE, counters 0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Run-control sequencer for the single-cycle 8-bit CPU.
// Decodes opcode/flags into datapath controls, gated by the run FSM.
module cpu_sequencer #(
   parameter int STACK_DEPTH = 8,
   parameter int CNT_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_stepMode,
   input  logic             i_step,
   input  logic [4:0]       i_opcodeFunc,
   input  logic             i_halt,
   input  logic             i_Cout,
   input  logic             i_Zout,
   output logic [3:0]       o_aluOp,
   output logic             o_regWriteEn,
   output logic             o_memWriteEn,
   output logic             o_cWriteEn,
   output logic             o_zWriteEn,
   output logic             o_immAndmem,
   output logic             o_stm,
   output logic             o_ldm,
   output logic             o_branch,
   output logic             o_jmp,
   output logic             o_ret,
   output logic             o_push,
   output logic             o_pop,
   output logic             o_pcEn,
   output logic             o_running,
   output logic             o_halted,
   output logic             o_faulted,
   output logic [1:0]       o_faultCode,
   output logic [3:0]       o_stackDepth,
   output logic [CNT_W-1:0] o_retireCount
);

   typedef enum logic [1:0] {
      S_IDLE, S_RUN, S_HALTED, S_FAULT
   } state_t;

   localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

   state_t           r_state, w_next;
   logic [1:0]       r_fault, w_fault_nxt;
   logic [3:0]       r_depth;
   logic [CNT_W-1:0] r_cnt;

   logic [3:0] w_alu;
   logic       w_reg, w_mem, w_cw, w_zw, w_imm, w_stm, w_ldm;
   logic       w_br, w_jmp, w_ret, w_push, w_pop, w_illegal;
   logic       w_exec, w_ovf, w_unf, w_do;

   // Raw decode, before run-control gating
   always_comb begin
      w_alu = 4'b0000;
      w_reg = 1'b0; w_mem = 1'b0; w_cw = 1'b0; w_zw = 1'b0;
      w_imm = 1'b0; w_stm = 1'b0; w_ldm = 1'b0; w_br = 1'b0;
      w_jmp = 1'b0; w_ret = 1'b0; w_push = 1'b0; w_pop = 1'b0;
      w_illegal = 1'b0;
      casez (i_opcodeFunc)
         5'b0????: begin
            w_alu = {1'b0, i_opcodeFunc[2:0]};
            w_reg = 1'b1; w_cw = 1'b1; w_zw = 1'b1;
            w_imm = i_opcodeFunc[3];
         end
         5'b10000: begin
            w_imm = 1'b1; w_ldm = 1'b1; w_reg = 1'b1;
         end
         5'b10001: begin
            w_imm = 1'b1; w_stm = 1'b1; w_mem = 1'b1;
         end
         5'b10010, 5'b10011, 5'b10100, 5'b10101: begin
            w_alu = {2'b10, i_opcodeFunc[1:0] - 2'b10};
            w_reg = 1'b1; w_cw = 1'b1; w_zw = 1'b1;
         end
         5'b11000: w_jmp = 1'b1;
         5'b11001: begin
            w_jmp = 1'b1; w_push = 1'b1;
         end
         5'b11010: begin
            w_ret = 1'b1; w_pop = 1'b1;
         end
         5'b111??: begin
            w_br = i_opcodeFunc[1] ? (i_Cout ^ i_opcodeFunc[0])
                                   : (i_Zout ^ i_opcodeFunc[0]);
         end
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_exec = (r_state == S_RUN) & (~i_stepMode | i_step);
   assign w_ovf  = w_push & (r_depth == DEPTH_MAX);
   assign w_unf  = w_pop & (r_depth == 4'd0);
   assign w_do   = w_exec & ~i_rst & ~i_halt & ~w_illegal
                 & ~w_ovf & ~w_unf;

   assign o_aluOp      = w_do ? w_alu : 4'b0000;
   assign o_regWriteEn = w_do & w_reg;
   assign o_memWriteEn = w_do & w_mem;
   assign o_cWriteEn   = w_do & w_cw;
   assign o_zWriteEn   = w_do & w_zw;
   assign o_immAndmem  = w_do & w_imm;
   assign o_stm        = w_do & w_stm;
   assign o_ldm        = w_do & w_ldm;
   assign o_branch     = w_do & w_br;
   assign o_jmp        = w_do & w_jmp;
   assign o_ret        = w_do & w_ret;
   assign o_push       = w_do & w_push;
   assign o_pop        = w_do & w_pop;
   assign o_pcEn       = w_do;

   always_comb begin
      w_next      = r_state;
      w_fault_nxt = r_fault;
      case (r_state)
         S_IDLE: if (i_start) w_next = S_RUN;
         S_RUN: begin
            if (w_exec) begin
               if (i_halt) begin
                  w_next = S_HALTED;
               end else if (w_illegal) begin
                  w_next = S_FAULT; w_fault_nxt = 2'b01;
               end else if (w_ovf) begin
                  w_next = S_FAULT; w_fault_nxt = 2'b10;
               end else if (w_unf) begin
                  w_next = S_FAULT; w_fault_nxt = 2'b11;
               end
            end
         end
         default: w_next = r_state;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_fault <= 2'b00;
         r_depth <= 4'd0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_fault <= w_fault_nxt;
         if (w_do) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_push)     r_depth <= r_depth + 4'd1;
            else if (w_pop) r_depth <= r_depth - 4'd1;
         end
      end
   end

   assign o_running     = (r_state == S_RUN);
   assign o_halted      = (r_state == S_HALTED);
   assign o_faulted     = (r_state == S_FAULT);
   assign o_faultCode   = r_fault;
   assign o_stackDepth  = r_depth;
   assign o_retireCount = r_cnt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed plus random stimulus for cpu_sequencer against an
// opcode-table reference model.
module tb_cpu_sequencer;

   localparam int SD = 8;
   localparam int CW = 16;

   logic clk, rst, start, stepMode, step_i, halt, Cout, Zout;
   logic [4:0] op;
   logic [3:0] aluOp;
   logic regWriteEn, memWriteEn, cWriteEn, zWriteEn, immAndmem;
   logic stm, ldm, branch, jmp, ret, push, pop, pcEn;
   logic running, halted, faulted;
   logic [1:0] faultCode;
   logic [3:0] stackDepth;
   logic [CW-1:0] retireCount;

   int ntests = 0;
   int nfail  = 0;

   // model: 0 idle, 1 run, 2 halted, 3 fault
   int ms = 0, md = 0, mf = 0;
   int mc = 0;

   cpu_sequencer #(.STACK_DEPTH(SD), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_stepMode(stepMode), .i_step(step_i),
      .i_opcodeFunc(op), .i_halt(halt),
      .i_Cout(Cout), .i_Zout(Zout),
      .o_aluOp(aluOp), .o_regWriteEn(regWriteEn),
      .o_memWriteEn(memWriteEn), .o_cWriteEn(cWriteEn),
      .o_zWriteEn(zWriteEn), .o_immAndmem(immAndmem),
      .o_stm(stm), .o_ldm(ldm), .o_branch(branch),
      .o_jmp(jmp), .o_ret(ret), .o_push(push), .o_pop(pop),
      .o_pcEn(pcEn), .o_running(running), .o_halted(halted),
      .o_faulted(faulted), .o_faultCode(faultCode),
      .o_stackDepth(stackDepth), .o_retireCount(retireCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      ntests++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock: drive at negedge, check controls, clock, check status
   task automatic cyc(input logic r, input logic s,
                      input logic sm, input logic st,
                      input int o, input logic h,
                      input logic c, input logic z,
                      input string tag);
      logic [16:0] ectl, actl;
      logic [24:0] est, ast;
      int  alu;
      bit  rw, mw, cwe, zwe, im, sm_, lm, br, jp, rt, ps, pp;
      bit  legal, jsb, rtn, ex, done;
      rst = r; start = s; stepMode = sm; step_i = st;
      op = 5'(o); halt = h; Cout = c; Zout = z;
      #1;
      legal = !(o == 22 || o == 23 || o == 27);
      jsb = (o == 25);
      rtn = (o == 26);
      ex = (ms == 1) && (!sm || st) && !r;
      done = ex && !h && legal && !(jsb && md == SD)
           && !(rtn && md == 0);
      alu = 0;
      {rw, mw, cwe, zwe, im, sm_, lm, br, jp, rt, ps, pp} = '0;
      if (done) begin
         if (o < 16) begin
            alu = o % 8; rw = 1; cwe = 1; zwe = 1; im = (o >= 8);
         end else if (o == 16) begin
            im = 1; lm = 1; rw = 1;
         end else if (o == 17) begin
            im = 1; sm_ = 1; mw = 1;
         end else if (o >= 18 && o <= 21) begin
            alu = 8 + (o - 18); rw = 1; cwe = 1; zwe = 1;
         end else if (o == 24) begin
            jp = 1;
         end else if (o == 25) begin
            jp = 1; ps = 1;
         end else if (o == 26) begin
            rt = 1; pp = 1;
         end else if (o == 28) br = z;
         else if (o == 29) br = !z;
         else if (o == 30) br = c;
         else if (o == 31) br = !c;
      end
      ectl = {4'(alu), rw, mw, cwe, zwe, im, sm_, lm,
              br, jp, rt, ps, pp, done};
      actl = {aluOp, regWriteEn, memWriteEn, cWriteEn, zWriteEn,
              immAndmem, stm, ldm, branch, jmp, ret, push, pop,
              pcEn};
      check({tag, ".ctl"}, 32'(actl), 32'(ectl));
      @(posedge clk);
      if (r) begin
         ms = 0; md = 0; mc = 0; mf = 0;
      end else if (ms == 0) begin
         if (s) ms = 1;
      end else if (ms == 1 && ex) begin
         if (h) ms = 2;
         else if (!legal) begin ms = 3; mf = 1; end
         else if (jsb && md == SD) begin ms = 3; mf = 2; end
         else if (rtn && md == 0) begin ms = 3; mf = 3; end
         else begin
            mc = (mc + 1) % (1 << CW);
            md = md + (jsb ? 1 : 0) - (rtn ? 1 : 0);
         end
      end
      @(negedge clk);
      est = {ms == 1, ms == 2, ms == 3, 2'(mf), 4'(md), 16'(mc)};
      ast = {running, halted, faulted, faultCode, stackDepth,
             retireCount};
      check({tag, ".st"}, 32'(ast), 32'(est));
   endtask

   task automatic run(input int o, input string tag);
      cyc(0, 0, 0, 0, o, 0, 0, 0, tag);
   endtask

   initial begin
      rst = 1; start = 0; stepMode = 0; step_i = 0;
      op = '0; halt = 0; Cout = 0; Zout = 0;
      @(negedge clk);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "rst0");
      cyc(0, 0, 0, 1, 2, 0, 0, 0, "idle_step");
      cyc(0, 1, 0, 0, 2, 0, 0, 0, "start");
      repeat (3) run(5'b00010, "sub");
      check("cnt3", 32'(retireCount), 32'd3);
      cyc(0, 0, 0, 0, 28, 0, 0, 1, "bz_t");
      cyc(0, 0, 0, 0, 28, 0, 0, 0, "bz_nt");
      for (int i = 0; i < 5; i++)
         cyc(0, 0, 1, (i == 1 || i == 3), 16, 0, 0, 0, "stepldm");
      check("cnt7", 32'(retireCount), 32'd7);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "rst1");
      cyc(0, 1, 0, 0, 0, 0, 0, 0, "start1");
      repeat (SD) run(25, "jsb");
      check("depth8", 32'(stackDepth), 32'(SD));
      run(25, "jsb_ovf");
      check("fc_ovf", 32'(faultCode), 32'd2);
      run(0, "fault_hold");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "rst2");
      cyc(0, 1, 0, 0, 0, 0, 0, 0, "start2");
      run(26, "ret_unf");
      check("fc_unf", 32'(faultCode), 32'd3);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "rst3");
      cyc(0, 1, 0, 0, 0, 0, 0, 0, "start3");
      run(22, "illegal");
      check("fc_ill", 32'(faultCode), 32'd1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "rst4");
      cyc(0, 1, 0, 0, 0, 0, 0, 0, "start4");
      run(8, "addi");
      cyc(0, 0, 0, 0, 0, 1, 0, 0, "halt");
      check("halted", 32'(halted), 32'd1);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, "start_ign");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "rst5");
      cyc(0, 1, 0, 0, 0, 0, 0, 0, "start5");
      run(19, "shift");
      run(17, "stm");
      cyc(1, 0, 0, 0, 12, 0, 0, 0, "rst_mid");
      for (int i = 0; i < 1500; i++) begin
         logic r, s, sm, st, h;
         int o;
         r  = ($urandom_range(0, 99) == 0)
           || (ms >= 2 && $urandom_range(0, 9) == 0);
         s  = ($urandom_range(0, 3) == 0);
         sm = ($urandom_range(0, 4) == 0);
         st = $urandom_range(0, 1) == 1;
         h  = ($urandom_range(0, 49) == 0);
         case ($urandom_range(0, 3))
            0: o = 25;
            1: o = 26;
            default: o = $urandom_range(0, 31);
         endcase
         if (o == 22 || o == 23 || o == 27)
            if ($urandom_range(0, 3) != 0) o = 24;
         cyc(r, s, sm, st, o, h, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, "rand");
      end
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
